// File: rtl/fir_pkg.sv
// Shared widths, filter timing constants and the state encoding for the FIR sample sequencer.
package fir_pkg;

    localparam int SAMPLE_W               = 16;
    localparam int NUM_TAPS               = 8;
    localparam int FILTER_LATENCY         = 9;
    localparam int TIMEOUT_CYCLES_DEFAULT = 32;

    // Sequencer states, kept as plain constants so legacy tools can share the encoding.
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t ST_IDLE      = 3'd0;
    localparam seq_state_t ST_START     = 3'd1;
    localparam seq_state_t ST_WAIT_DONE = 3'd2;
    localparam seq_state_t ST_CAPTURE   = 3'd3;
    localparam seq_state_t ST_OUTPUT    = 3'd4;

endpackage

// File: rtl/fir_sample_sequencer_if.sv
// Sample stream, filter control and result stream of the FIR sample sequencer.
interface fir_sample_sequencer_if;
    import fir_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_data;
    logic                filt_start;
    logic [SAMPLE_W-1:0] filt_data;
    logic                filt_done;
    logic [SAMPLE_W-1:0] filt_result;
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_data;
    logic                timeout_err;

    modport slave (
        input  in_valid, in_data, filt_done, filt_result, out_ready,
        output in_ready, filt_start, filt_data, out_valid, out_data, timeout_err
    );

    modport master (
        output in_valid, in_data, filt_done, filt_result, out_ready,
        input  in_ready, filt_start, filt_data, out_valid, out_data, timeout_err
    );

endinterface

// File: rtl/fir_seq_fifo.sv
// Synchronous sample FIFO; head word is visible combinationally, pointers carry an extra wrap bit.
module fir_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which words are valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fir_sample_sequencer.sv
// Feeds buffered samples to the FIR stage one at a time and returns each result on a stream.
// Optional statistics counters are enabled with `define FIR_SEQ_STATS_EN.
module fir_sample_sequencer
    import fir_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    fir_sample_sequencer_if.slave bus
`ifdef FIR_SEQ_STATS_EN
    ,
    output logic [15:0]           stat_done_cnt,
    output logic [7:0]            stat_timeout_cnt
`endif
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t          state_q, state_d;
    logic                filt_start_q, filt_start_d;
    logic [SAMPLE_W-1:0] filt_data_q, filt_data_d;
    logic                out_valid_q, out_valid_d;
    logic [SAMPLE_W-1:0] out_data_q, out_data_d;
    logic                timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [SAMPLE_W-1:0] fifo_head;

    assign bus.in_ready = reset_n && !fifo_full;
    assign fifo_push    = bus.in_valid && bus.in_ready;
    assign fifo_pop     = (state_q == ST_IDLE) && !fifo_empty;

    fir_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (bus.in_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // NOTE: every signal gets a hold/default value first, so no latch can be inferred.
    always_comb begin
        state_d       = state_q;
        filt_start_d  = 1'b0;
        filt_data_d   = filt_data_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    filt_data_d  = fifo_head;
                    filt_start_d = 1'b1;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // filt_done is only looked at here, so stale or unknown pulses elsewhere are harmless.
                if (bus.filt_done) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end
            ST_CAPTURE: begin
                out_data_d  = bus.filt_result;
                out_valid_d = 1'b1;
                state_d     = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            filt_start_q  <= 1'b0;
            filt_data_q   <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            filt_start_q  <= filt_start_d;
            filt_data_q   <= filt_data_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.filt_start  = filt_start_q;
    assign bus.filt_data   = filt_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.timeout_err = timeout_err_q;

`ifdef FIR_SEQ_STATS_EN
    logic        done_evt, tmo_evt;
    logic [15:0] done_cnt_q, done_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;

    assign done_evt = (state_q == ST_OUTPUT) && bus.out_ready;
    assign tmo_evt  = (state_q == ST_WAIT_DONE) && (state_d == ST_IDLE);

    always_comb begin
        done_cnt_d = done_cnt_q + 16'(done_evt);
        tmo_cnt_d  = tmo_cnt_q + 8'(tmo_evt);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            done_cnt_q <= done_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign stat_done_cnt    = done_cnt_q;
    assign stat_timeout_cnt = tmo_cnt_q;
`endif

endmodule
